// File: rtl/lcd1602_seq.sv
// ---------------------------------------------------------------------------
// lcd1602_seq
//
// Write sequencer between the Z80 I/O decode and an HD44780-compatible
// LCD1602 panel. CPU writes ({rs, data}) are queued in a small FIFO and then
// replayed on the LCD bus with programmed setup / enable-width / hold times.
// After each entry the sequencer waits the instruction execution delay. The
// panel is used write-only: RW is tied low and the busy flag is never read.
//
// Optional feature macro:
//   LCD_NIBBLE_MODE_EN - 4-bit interface. Each entry is sent as two E
//                        pulses (high nibble, then low nibble) on
//                        lcd_d[7:4], with lcd_d[3:0] held at 0.
//                        Undefined: 8-bit interface, one E pulse per entry.
//
// Ports:
//   in_clock  in   system clock; all logic on its rising edge
//   rst       in   synchronous active-high reset
//   wr_stb    in   one-cycle write request (already synchronous)
//   wr_rs     in   RS for the request (0 = command, 1 = data)
//   wr_data   in   byte for the request
//   clr_ovf   in   clears ovf (a coincident drop wins)
//   full      out  FIFO holds 2^FIFO_AW entries
//   busy      out  FIFO non-empty or sequencer not idle
//   ovf       out  sticky: a write was dropped
//   lcd_e     out  LCD enable
//   lcd_rs    out  LCD register select
//   lcd_rw    out  LCD read/write, constant 0
//   lcd_d     out  LCD data bus
// ---------------------------------------------------------------------------
module lcd1602_seq #(
   parameter int FIFO_AW = 3,
   parameter int T_AS    = 2,
   parameter int T_PW    = 12,
   parameter int T_H     = 2,
   parameter int T_SHORT = 1200,
   parameter int T_LONG  = 40000
) (
   input  logic       in_clock,
   input  logic       rst,
   input  logic       wr_stb,
   input  logic       wr_rs,
   input  logic [7:0] wr_data,
   input  logic       clr_ovf,
   output logic       full,
   output logic       busy,
   output logic       ovf,
   output logic       lcd_e,
   output logic       lcd_rs,
   output logic       lcd_rw,
   output logic [7:0] lcd_d
);

   localparam int DEPTH  = 1 << FIFO_AW;
   localparam int T_MAX0 = (T_LONG > T_SHORT) ? T_LONG : T_SHORT;
   localparam int T_MAX  = (T_MAX0 > T_PW) ? T_MAX0 : T_PW;
   localparam int CW     = $clog2(T_MAX + 1);

   // The counter is loaded with (duration - 1) on state entry and the state
   // is left on the cycle it reads zero, giving exactly 'duration' cycles.
   localparam logic [CW-1:0] LD_AS    = CW'(T_AS - 1);
   localparam logic [CW-1:0] LD_PW    = CW'(T_PW - 1);
   localparam logic [CW-1:0] LD_H     = CW'(T_H - 1);
   localparam logic [CW-1:0] LD_SHORT = CW'(T_SHORT - 1);
   localparam logic [CW-1:0] LD_LONG  = CW'(T_LONG - 1);

   localparam logic [FIFO_AW:0] DEPTH_C = (FIFO_AW + 1)'(DEPTH);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_EHIGH,
      S_HOLD,
      S_WAIT
   } state_t;

   // ------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------
   state_t               state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [8:0]           entry_q, entry_d;

   logic [8:0]           mem_q [DEPTH];
   logic [FIFO_AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [FIFO_AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [FIFO_AW:0]     count_q, count_d;

   logic                 full_q, full_d;
   logic                 busy_q, busy_d;
   logic                 ovf_q, ovf_d;
   logic                 lcd_e_q, lcd_e_d;
   logic                 lcd_rs_q, lcd_rs_d;
   logic [7:0]           lcd_d_q, lcd_d_d;

`ifdef LCD_NIBBLE_MODE_EN
   // 0 while the high nibble is on the bus, 1 for the low nibble.
   logic                 nib_q, nib_d;
`endif

   logic                 pop;
   logic                 push;
   logic                 drop;
   logic                 is_long;
   logic [8:0]           head;

   // ------------------------------------------------------------------
   // FIFO control
   // ------------------------------------------------------------------
   assign head = mem_q[rd_ptr_q];

   // A pop frees a slot in the same cycle, so a strobe on a full FIFO is
   // still accepted when the sequencer is taking the head.
   assign pop  = (state_q == S_IDLE) && (count_q != '0);
   assign push = wr_stb && ((count_q != DEPTH_C) || pop);
   assign drop = wr_stb && !push;

   // Clear display (0x01) and return home (0x02/0x03) need the long wait.
   assign is_long = !entry_q[8] && (entry_q[7:2] == 6'd0) && (entry_q[1:0] != 2'd0);

   always_comb begin
      count_d  = count_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (push && !pop) begin
         count_d = count_q + 1'b1;
      end else if (pop && !push) begin
         count_d = count_q - 1'b1;
      end
   end

   always_comb begin
      ovf_d = ovf_q;
      if (drop) begin
         ovf_d = 1'b1;
      end else if (clr_ovf) begin
         ovf_d = 1'b0;
      end
      full_d = (count_d == DEPTH_C);
      busy_d = (state_d != S_IDLE) || (count_d != '0);
   end

   // ------------------------------------------------------------------
   // Sequencer next-state and bus outputs
   // ------------------------------------------------------------------
   always_comb begin
      state_d  = state_q;
      cnt_d    = (cnt_q != '0) ? (cnt_q - 1'b1) : cnt_q;
      entry_d  = entry_q;
      lcd_e_d  = 1'b0;
      lcd_rs_d = lcd_rs_q;
      lcd_d_d  = lcd_d_q;
`ifdef LCD_NIBBLE_MODE_EN
      nib_d    = nib_q;
`endif

      case (state_q)
         S_IDLE: begin
            if (pop) begin
               entry_d  = head;
               lcd_rs_d = head[8];
`ifdef LCD_NIBBLE_MODE_EN
               lcd_d_d  = {head[7:4], 4'h0};
               nib_d    = 1'b0;
`else
               lcd_d_d  = head[7:0];
`endif
               cnt_d    = LD_AS;
               state_d  = S_SETUP;
            end
         end

         S_SETUP: begin
            if (cnt_q == '0) begin
               lcd_e_d = 1'b1;
               cnt_d   = LD_PW;
               state_d = S_EHIGH;
            end
         end

         S_EHIGH: begin
            lcd_e_d = 1'b1;
            if (cnt_q == '0) begin
               lcd_e_d = 1'b0;
               cnt_d   = LD_H;
               state_d = S_HOLD;
            end
         end

         S_HOLD: begin
            if (cnt_q == '0) begin
               cnt_d   = is_long ? LD_LONG : LD_SHORT;
               state_d = S_WAIT;
`ifdef LCD_NIBBLE_MODE_EN
               // After the high nibble, go straight back to SETUP with the
               // low nibble; only the second pass is followed by WAIT.
               if (!nib_q) begin
                  nib_d   = 1'b1;
                  lcd_d_d = {entry_q[3:0], 4'h0};
                  cnt_d   = LD_AS;
                  state_d = S_SETUP;
               end
`endif
            end
         end

         S_WAIT: begin
            if (cnt_q == '0) begin
               state_d = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------
   always_ff @(posedge in_clock) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         entry_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
         busy_q   <= 1'b0;
         ovf_q    <= 1'b0;
         lcd_e_q  <= 1'b0;
         lcd_rs_q <= 1'b0;
         lcd_d_q  <= '0;
`ifdef LCD_NIBBLE_MODE_EN
         nib_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         entry_q  <= entry_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         full_q   <= full_d;
         busy_q   <= busy_d;
         ovf_q    <= ovf_d;
         lcd_e_q  <= lcd_e_d;
         lcd_rs_q <= lcd_rs_d;
         lcd_d_q  <= lcd_d_d;
`ifdef LCD_NIBBLE_MODE_EN
         nib_q    <= nib_d;
`endif
      end
   end

   // FIFO storage carries no reset; occupancy is tracked by the pointers.
   always_ff @(posedge in_clock) begin
      if (push) begin
         mem_q[wr_ptr_q] <= {wr_rs, wr_data};
      end
   end

   assign full   = full_q;
   assign busy   = busy_q;
   assign ovf    = ovf_q;
   assign lcd_e  = lcd_e_q;
   assign lcd_rs = lcd_rs_q;
   assign lcd_rw = 1'b0;
   assign lcd_d  = lcd_d_q;

endmodule

// File: tb/tb_lcd1602_seq.sv
// ---------------------------------------------------------------------------
// tb_lcd1602_seq
//
// Self-checking bench for lcd1602_seq. A timeline model derives every output
// from the time of each pop: E windows, bus values and busy follow from the
// entry length in cycles. The outputs are compared on every falling edge,
// and directed scenarios add literal timing/data expectations.
// Builds with or without LCD_NIBBLE_MODE_EN.
// ---------------------------------------------------------------------------
module tb_lcd1602_seq;

   localparam int FIFO_AW = 3;
   localparam int DEPTH   = 8;
   localparam int T_AS    = 2;
   localparam int T_PW    = 12;
   localparam int T_H     = 2;
   localparam int T_SHORT = 1200;
   localparam int T_LONG  = 40000;
`ifdef LCD_NIBBLE_MODE_EN
   localparam int PASSES  = 2;
`else
   localparam int PASSES  = 1;
`endif
   localparam int PASS_LEN = T_AS + T_PW + T_H;
   localparam int EXTRA    = (PASSES - 1) * PASS_LEN;

   logic       clk = 1'b0;
   logic       rst;
   logic       wr_stb;
   logic       wr_rs;
   logic [7:0] wr_data;
   logic       clr_ovf;
   logic       full;
   logic       busy;
   logic       ovf;
   logic       lcd_e;
   logic       lcd_rs;
   logic       lcd_rw;
   logic [7:0] lcd_d;

   lcd1602_seq #(
      .FIFO_AW (FIFO_AW),
      .T_AS    (T_AS),
      .T_PW    (T_PW),
      .T_H     (T_H),
      .T_SHORT (T_SHORT),
      .T_LONG  (T_LONG)
   ) dut (
      .in_clock (clk),
      .rst      (rst),
      .wr_stb   (wr_stb),
      .wr_rs    (wr_rs),
      .wr_data  (wr_data),
      .clr_ovf  (clr_ovf),
      .full     (full),
      .busy     (busy),
      .ovf      (ovf),
      .lcd_e    (lcd_e),
      .lcd_rs   (lcd_rs),
      .lcd_rw   (lcd_rw),
      .lcd_d    (lcd_d)
   );

   initial forever #5 clk = ~clk;

   int     n_cmp   = 0;
   int     n_fail  = 0;
   int     n_print = 0;
   longint cyc     = 0;
   bit     chk_en  = 1'b0;

   // ---------------- timeline model ----------------
   logic [8:0] mq [$];
   logic [8:0] m_cur  = '0;
   bit         m_have = 1'b0;
   longint     m_pop  = -1000000;
   longint     m_end  = -1;
   bit         m_ovf  = 1'b0;

   // Cycles from the pop edge to the edge where the sequencer is idle again.
   function automatic longint xfer_len(input logic [8:0] e);
      bit lng;
      lng = (e[8] == 1'b0) && (e[7:0] == 8'h01 || e[7:0] == 8'h02 || e[7:0] == 8'h03);
      return longint'(PASSES * PASS_LEN) + (lng ? T_LONG : T_SHORT);
   endfunction

   function automatic logic [7:0] pass_byte(input logic [7:0] b, input int k);
      if (PASSES == 1) return b;
      return (k == 0) ? {b[7:4], 4'h0} : {b[3:0], 4'h0};
   endfunction

   function automatic logic exp_e();
      longint r;
      longint rr;
      logic   e;
      r = cyc - m_pop;
      e = 1'b0;
      for (int k = 0; k < PASSES; k++) begin
         rr = r - longint'(k * PASS_LEN);
         if (rr >= T_AS && rr < T_AS + T_PW) e = 1'b1;
      end
      return e;
   endfunction

   function automatic logic [7:0] exp_d();
      if (!m_have) return 8'h00;
      return pass_byte(m_cur[7:0], (cyc - m_pop >= PASS_LEN) ? 1 : 0);
   endfunction

   initial begin
      forever begin
         @(posedge clk);
         cyc = cyc + 1;
         if (rst) begin
            mq.delete();
            m_have = 1'b0;
            m_cur  = '0;
            m_pop  = -1000000;
            m_end  = cyc;
            m_ovf  = 1'b0;
         end else begin
            if (cyc > m_end && mq.size() > 0) begin
               m_cur  = mq.pop_front();
               m_have = 1'b1;
               m_pop  = cyc;
               m_end  = cyc + xfer_len(m_cur);
            end
            if (wr_stb && mq.size() >= DEPTH) begin
               m_ovf = 1'b1;
            end else begin
               if (wr_stb) mq.push_back({wr_rs, wr_data});
               if (clr_ovf) m_ovf = 1'b0;
            end
         end
      end
   end

   // ---------------- per-cycle compare + pulse recorder ----------------
   longint     rise_t [$];
   logic [7:0] rise_d [$];
   logic       rise_rs [$];
   longint     fall_t [$];
   logic       prev_e = 1'b0;
   logic       x_e, x_rs, x_busy, x_full;
   logic [7:0] x_d;

   initial begin
      forever begin
         @(negedge clk);
         if (chk_en) begin
            x_e    = exp_e();
            x_rs   = m_have ? m_cur[8] : 1'b0;
            x_d    = exp_d();
            x_busy = (cyc < m_end) || (mq.size() > 0);
            x_full = (mq.size() == DEPTH);
            n_cmp++;
            if (lcd_e !== x_e || lcd_rs !== x_rs || lcd_d !== x_d || busy !== x_busy ||
                full !== x_full || ovf !== m_ovf || lcd_rw !== 1'b0) begin
               n_fail++;
               if (n_print < 20) begin
                  n_print++;
                  $display("FAIL cycle_check edge %0d: got e=%b rs=%b d=%02h busy=%b full=%b ovf=%b rw=%b, want e=%b rs=%b d=%02h busy=%b full=%b ovf=%b rw=0",
                           cyc, lcd_e, lcd_rs, lcd_d, busy, full, ovf, lcd_rw,
                           x_e, x_rs, x_d, x_busy, x_full, m_ovf);
               end
            end
         end
         if (lcd_e === 1'b1 && !prev_e) begin
            rise_t.push_back(cyc);
            rise_d.push_back(lcd_d);
            rise_rs.push_back(lcd_rs);
         end
         if (lcd_e === 1'b0 && prev_e) fall_t.push_back(cyc);
         prev_e = (lcd_e === 1'b1);
      end
   end

   // ---------------- helpers ----------------
   task automatic check(input string name, input logic signed [63:0] act,
                        input logic signed [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, want %0d", name, act, exp);
      end
   endtask

   function automatic longint rise_at(input int i);
      if (i < rise_t.size()) return rise_t[i];
      return -1;
   endfunction

   function automatic longint fall_at(input int i);
      if (i < fall_t.size()) return fall_t[i];
      return -1;
   endfunction

   function automatic int rise_d_at(input int i);
      if (i < rise_d.size()) return int'(rise_d[i]);
      return -1;
   endfunction

   task automatic clear_obs();
      rise_t.delete();
      rise_d.delete();
      rise_rs.delete();
      fall_t.delete();
   endtask

   // Called on a falling edge; the request is sampled on the next rising edge.
   task automatic strobe(input logic rs, input logic [7:0] d, input logic clr,
                         output longint edge_n);
      wr_stb  = 1'b1;
      wr_rs   = rs;
      wr_data = d;
      clr_ovf = clr;
      edge_n  = cyc + 1;
      $display("WR  edge %0d rs=%0d data=0x%02h clr_ovf=%0d", edge_n, rs, d, clr);
      @(negedge clk);
      wr_stb  = 1'b0;
      clr_ovf = 1'b0;
   endtask

   task automatic wait_idle(input string name, input int budget, output longint t);
      int k;
      k = 0;
      while (busy !== 1'b0 && k < budget) begin
         @(negedge clk);
         k++;
      end
      t = cyc;
      if (busy !== 1'b0) begin
         n_cmp++;
         n_fail++;
         $display("FAIL %s: busy still high after %0d cycles, want low", name, budget);
      end
   endtask

   task automatic single_write(input string tag);
      longint s;
      longint t;
      clear_obs();
      strobe(1'b1, 8'h41, 1'b0, s);
      @(negedge clk);
      check({tag, "_rs_n1"}, lcd_rs, 1);
      check({tag, "_d_n1"}, lcd_d, pass_byte(8'h41, 0));
      check({tag, "_e_n1"}, lcd_e, 0);
      wait_idle(tag, 5000, t);
      check({tag, "_busy_drop"}, t - s, 1217 + EXTRA);
      check({tag, "_e_rise"}, rise_at(0) - s, 3);
      check({tag, "_e_fall"}, fall_at(0) - s, 15);
      check({tag, "_pulses"}, rise_t.size(), PASSES);
   endtask

   // ---------------- directed scenarios ----------------
   initial begin
      longint s;
      longint s2;
      longint t;
      longint s0;
      longint pop_edge;
      int     k;

      rst = 1'b1; wr_stb = 1'b0; wr_rs = 1'b0; wr_data = 8'h00; clr_ovf = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_e", lcd_e, 0);
      check("rst_rs", lcd_rs, 0);
      check("rst_d", lcd_d, 0);
      check("rst_busy", busy, 0);
      check("rst_full", full, 0);
      check("rst_ovf", ovf, 0);
      check("rst_rw", lcd_rw, 0);
      chk_en = 1'b1;
      rst = 1'b0;
      @(negedge clk);

      // Single data write.
      single_write("single");

      // Clear command followed by data: long wait between E rises.
      clear_obs();
      strobe(1'b0, 8'h01, 1'b0, s);
      strobe(1'b1, 8'h20, 1'b0, s2);
      wait_idle("clear", 45000, t);
      check("clear_first_rise", rise_at(0) - s, 3);
      check("clear_gap", rise_at(PASSES) - rise_at(0), 40017 + EXTRA);
      check("clear_rs1", rise_rs.size() > PASSES ? int'(rise_rs[PASSES]) : -1, 1);

      // Function set (0x38) is a normal instruction: short wait.
      clear_obs();
      strobe(1'b0, 8'h38, 1'b0, s);
      strobe(1'b1, 8'h20, 1'b0, s2);
      wait_idle("short", 5000, t);
      check("short_gap", rise_at(PASSES) - rise_at(0), 1217 + EXTRA);
      check("short_d0", rise_d_at(0), pass_byte(8'h38, 0));

      // 0xA5: nibble split (4-bit build) or full byte (8-bit build).
      clear_obs();
      strobe(1'b1, 8'hA5, 1'b0, s);
      strobe(1'b1, 8'h20, 1'b0, s2);
      wait_idle("a5", 5000, t);
      for (int i = 0; i < PASSES; i++) check("a5_data", rise_d_at(i), pass_byte(8'hA5, i));
      check("a5_next_gap", rise_at(PASSES) - rise_at(PASSES - 1), 1217);
`ifdef LCD_NIBBLE_MODE_EN
      check("a5_nibble_gap", rise_at(1) - rise_at(0), 16);
      check("a5_low_zero", rise_d_at(1) & 15, 0);
`endif

      // Overflow: ten back-to-back strobes, the tenth with clr_ovf coincident.
      clear_obs();
      for (int i = 0; i < 10; i++) begin
         strobe(1'b1, 8'(i), (i == 9) ? 1'b1 : 1'b0, s);
         if (i == 7) check("ovf_full_n7", full, 0);
         if (i == 8) check("ovf_full_n8", full, 1);
      end
      check("ovf_set", ovf, 1);
      check("ovf_full_n9", full, 1);
      wait_idle("ovf_drain", 13000, t);
      check("ovf_pulses", rise_t.size(), 9 * PASSES);
      for (int j = 0; j < 9; j++) begin
         for (int p = 0; p < PASSES; p++) begin
            check("ovf_order", rise_d_at(j * PASSES + p), pass_byte(8'(j), p));
         end
      end
      check("ovf_sticky", ovf, 1);
      clr_ovf = 1'b1;
      @(negedge clk);
      clr_ovf = 1'b0;
      check("ovf_cleared", ovf, 0);

      // Push on full coincident with a pop is accepted.
      clear_obs();
      for (int i = 0; i < 9; i++) begin
         strobe(1'b1, 8'h30 + 8'(i), 1'b0, s);
         if (i == 0) s0 = s;
      end
      check("pof_full_before", full, 1);
      pop_edge = s0 + 2 + PASSES * PASS_LEN + T_SHORT;
      k = 0;
      while (cyc < pop_edge - 1 && k < 3000) begin
         @(negedge clk);
         k++;
      end
      check("pof_full_pre_pop", full, 1);
      strobe(1'b1, 8'h55, 1'b0, s);
      check("pof_ovf", ovf, 0);
      check("pof_full_after", full, 1);

      // Reset during EHIGH of the entry just popped.
      k = 0;
      while (lcd_e !== 1'b1 && k < 50) begin
         @(negedge clk);
         k++;
      end
      check("rst_mid_e_high", lcd_e, 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rst_mid_e", lcd_e, 0);
      check("rst_mid_busy", busy, 0);
      check("rst_mid_full", full, 0);
      check("rst_mid_ovf", ovf, 0);
      single_write("after_rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #1500000;
      $display("FAIL watchdog: simulation did not finish, edge %0d", cyc);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
      $fatal(1, "watchdog");
   end

endmodule
